deb_multi: RTL and testbench

//   N-channel button debouncer; successor to the single-channel debouncer.
//   Per channel: synchronises the raw pad, filters bounce with a stability counter,
//   and emits a level plus one-cycle press/release/long-press events.

---
 rtl/deb_multi_pkg.sv | 18 +
 rtl/deb_multi_chan.sv | 116 +++++++++++
 rtl/deb_multi.sv | 45 ++++
 tb/tb_deb_multi.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/deb_multi_pkg.sv
// Shared definitions for the multi-channel button debouncer.
//   CLK_HZ              system clock rate the defaults are derived for (12 MHz)
//   ms_to_cycles()      converts a duration in milliseconds to clock cycles
//   DEF_MAX_BTN_COUNT   default stability window (20 ms)
//   DEF_LONG_COUNT      default long-press hold time (500 ms)
`timescale 1ns / 1ps
package deb_multi_pkg;

  localparam int unsigned CLK_HZ = 12000000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEF_MAX_BTN_COUNT = ms_to_cycles(20);
  localparam int unsigned DEF_LONG_COUNT    = ms_to_cycles(500);

endpackage

// File: rtl/deb_multi_chan.sv
// deb_chan: one debouncer channel.
//   clk      system clock
//   rst      synchronous reset, active-high
//   btn_raw  asynchronous button pad, polarity per ACTIVE_LOW
//   out      debounced level, 1 = pressed
//   press    1-cycle pulse on out 0->1
//   rel      1-cycle pulse on out 1->0 ('release' is a reserved word)
//   long     1-cycle pulse after out has been held for LONG_COUNT cycles
`timescale 1ns / 1ps
module deb_chan
  import deb_multi_pkg::*;
#(
  parameter int unsigned MAX_BTN_COUNT = DEF_MAX_BTN_COUNT,
  parameter int unsigned LONG_COUNT    = DEF_LONG_COUNT,
  parameter int unsigned LONG_REPEAT   = 0,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic out,
  output logic press,
  output logic rel,
  output logic long
);

  localparam int unsigned CNT_W  = $clog2(MAX_BTN_COUNT);
  localparam int unsigned HCNT_W = $clog2(LONG_COUNT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_BTN_COUNT - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_COUNT - 1);
  localparam logic [HCNT_W-1:0] HCNT_SAT  = HCNT_W'(LONG_COUNT);
  // Raw pad level when the button is idle.
  localparam logic IDLE_PAD = (ACTIVE_LOW != 0);

  logic              sync0_q, sync0_d;
  logic              sync1_q, sync1_d;
  logic              s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              out_q, out_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;

  // The synchroniser carries the raw pad so nothing sits in front of the
  // first flop; polarity is corrected on its output instead, and reset loads
  // the idle pad level, which is 0 after correction.
  always_comb begin
    sync0_d = btn_raw;
    sync1_d = sync0_q;
    s       = sync1_q ^ IDLE_PAD;
  end

  always_comb begin
    cnt_d   = '0;
    out_d   = out_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d   = s;
        press_d = s;
        rel_d   = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Hold counter runs only while out is high; out_q is still 0 on the press
  // edge, so the count starts clean from every press. A long that would land
  // on the release edge is dropped so long never coincides with another pulse.
  always_comb begin
    hcnt_d = '0;
    long_d = 1'b0;
    if (out_q) begin
      if (hcnt_q == HCNT_LAST) begin
        long_d = ~rel_d;
        hcnt_d = (LONG_REPEAT != 0) ? '0 : HCNT_SAT;
      end else if (hcnt_q != HCNT_SAT) begin
        hcnt_d = hcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= IDLE_PAD;
      sync1_q <= IDLE_PAD;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      out_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      out_q   <= out_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign out   = out_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign long  = long_q;

endmodule

// File: rtl/deb_multi.sv
// deb_multi: N-channel button debouncer, one independent deb_chan per button.
//   clk      system clock, 12 MHz
//   rst      synchronous reset, active-high
//   btn_raw  asynchronous button pads, polarity per ACTIVE_LOW
//   out      debounced levels, 1 = pressed
//   press    1-cycle pulse per channel on out 0->1
//   rel      1-cycle pulse per channel on out 1->0 ('release' is a reserved word)
//   long     1-cycle pulse per channel on long hold
`timescale 1ns / 1ps
module deb_multi
  import deb_multi_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned MAX_BTN_COUNT = DEF_MAX_BTN_COUNT,
  parameter int unsigned LONG_COUNT    = DEF_LONG_COUNT,
  parameter int unsigned LONG_REPEAT   = 0,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] out,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] long
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    deb_chan #(
      .MAX_BTN_COUNT (MAX_BTN_COUNT),
      .LONG_COUNT    (LONG_COUNT),
      .LONG_REPEAT   (LONG_REPEAT),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw[i]),
      .out     (out[i]),
      .press   (press[i]),
      .rel     (rel[i]),
      .long    (long[i])
    );
  end

endmodule

// File: tb/tb_deb_multi.sv
// Directed bench for deb_multi: two instances (single and repeating long
// press) share the pads; expected output vectors are set by hand per step.
`timescale 1ns / 1ps
module tb_deb_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn = 2'b11;

  logic [1:0] out0, press0, rel0, long0;
  logic [1:0] out1, press1, rel1, long1;

  logic [1:0] eo = '0, ep = '0, er = '0, el = '0, elr = '0;

  int    nchecks = 0;
  int    nerrors = 0;
  string phase   = "reset";

  always #41.667 clk = ~clk;

  deb_multi #(
    .N_BTN(2), .MAX_BTN_COUNT(20), .LONG_COUNT(50), .LONG_REPEAT(0), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn),
    .out(out0), .press(press0), .rel(rel0), .long(long0)
  );

  deb_multi #(
    .N_BTN(2), .MAX_BTN_COUNT(20), .LONG_COUNT(50), .LONG_REPEAT(1), .ACTIVE_LOW(1)
  ) dut_r (
    .clk(clk), .rst(rst), .btn_raw(btn),
    .out(out1), .press(press1), .rel(rel1), .long(long1)
  );

  task automatic chk(input string which, input logic [7:0] obs, input logic [7:0] exp_v);
    nchecks++;
    assert (obs === exp_v) else begin
      nerrors++;
      $error("FAIL %s/%s: observed out,press,rel,long=%b expected %b", phase, which, obs, exp_v);
    end
  endtask

  // Advance one edge, then compare both instances against the expectations.
  task automatic cyc();
    @(posedge clk);
    #1;
    chk("rep0", {out0, press0, rel0, long0}, {eo, ep, er, el});
    chk("rep1", {out1, press1, rel1, long1}, {eo, ep, er, elr});
  endtask

  task automatic cyc_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    // Reset state
    cyc_n(2);
    rst = 1'b0;
    cyc_n(3);

    // 1: clean press on ch0, 40 cycles, then release
    phase = "clean";
    btn = 2'b10;
    cyc_n(21);
    eo = 2'b01; ep = 2'b01; cyc();
    ep = 2'b00; cyc_n(18);
    btn = 2'b11;
    cyc_n(21);
    eo = 2'b00; er = 2'b01; cyc();
    er = 2'b00; cyc_n(5);

    // 2: bounce every 3 cycles for 60 cycles, then stay pressed
    phase = "bounce";
    for (int seg = 0; seg < 20; seg++) begin
      btn = (seg % 2 == 1) ? 2'b11 : 2'b10;
      cyc_n(3);
    end
    btn = 2'b10;
    cyc_n(21);
    eo = 2'b01; ep = 2'b01; cyc();
    ep = 2'b00;
    btn = 2'b11;
    cyc_n(21);
    eo = 2'b00; er = 2'b01; cyc();
    er = 2'b00; cyc_n(5);

    // 3: 19-cycle glitch is rejected, 20-cycle glitch is accepted
    phase = "glitch19";
    btn = 2'b10; cyc_n(19);
    btn = 2'b11; cyc_n(30);
    phase = "glitch20";
    btn = 2'b10; cyc_n(20);
    btn = 2'b11; cyc();
    eo = 2'b01; ep = 2'b01; cyc();
    ep = 2'b00; cyc_n(19);
    eo = 2'b00; er = 2'b01; cyc();
    er = 2'b00; cyc_n(5);

    // 4: long press held 130 cycles after out rises
    phase = "long";
    btn = 2'b10;
    cyc_n(21);
    eo = 2'b01; ep = 2'b01; cyc();
    ep = 2'b00; cyc_n(49);
    el = 2'b01; elr = 2'b01; cyc();
    el = 2'b00; elr = 2'b00; cyc_n(49);
    elr = 2'b01; cyc();
    elr = 2'b00; cyc_n(30);
    btn = 2'b11;
    cyc_n(19);
    elr = 2'b01; cyc();
    elr = 2'b00; cyc();
    eo = 2'b00; er = 2'b01; cyc();
    er = 2'b00; cyc_n(5);

    // 5: reset with ch1 held and ch0 mid-count, both held through reset
    phase = "reset_mid";
    btn = 2'b01;
    cyc_n(21);
    eo = 2'b10; ep = 2'b10; cyc();
    ep = 2'b00; cyc_n(5);
    btn = 2'b00;
    cyc_n(12);
    rst = 1'b1;
    eo = 2'b00; cyc();
    rst = 1'b0;

    // 6: both channels come out of reset pressed on the same edge,
    //    then release one at a time
    phase = "dual";
    cyc_n(21);
    eo = 2'b11; ep = 2'b11; cyc();
    ep = 2'b00;
    btn = 2'b10;
    cyc_n(10);
    btn = 2'b11;
    cyc_n(11);
    eo = 2'b01; er = 2'b10; cyc();
    er = 2'b00; cyc_n(9);
    eo = 2'b00; er = 2'b01; cyc();
    er = 2'b00; cyc_n(3);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
